// File: rtl/dtcm_ctrl.sv
// dtcm_ctrl: tightly coupled data memory with a CPU port, a config (loader) port and a
// memory-mapped print FIFO.
//
// Ports
//   clk, resetn          clock (rising edge) and asynchronous active-low reset
//   mem_wren/mem_rden    CPU request strobes; a write wins if both are high
//   mem_addr             CPU word address
//   mem_wstrb/mem_wdata  CPU byte enables and write data
//   mem_rdata            response data, held until the next response
//   mem_ready            one-cycle response pulse, RD_LAT cycles after the request
//   mem_err              flags out-of-range accesses and dropped CPU writes
//   conf_sel             config port owns the memory; CPU writes are dropped
//   conf_rden/conf_wren  config full-word read/write strobes
//   conf_addr/conf_wdata config word address and write data
//   conf_rdata           registered config read data (read-first)
//   print_valid/value    head of the print FIFO (first-word fall-through)
//   print_ready          consumer pops the head when valid
//   print_ovf            sticky: a print byte was dropped on a full FIFO
module dtcm_ctrl #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DEPTH_LOG2 = 14,
    parameter int unsigned RD_LAT     = 1,
    parameter logic [31:0] PRINT_ADDR = 32'h0400_0000,
    parameter int unsigned PFIFO_LOG2 = 3
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                mem_wren,
    input  logic                mem_rden,
    input  logic [31:0]         mem_addr,
    input  logic [DATA_W/8-1:0] mem_wstrb,
    input  logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W-1:0]   mem_rdata,
    output logic                mem_ready,
    output logic                mem_err,
    input  logic                conf_sel,
    input  logic                conf_rden,
    input  logic                conf_wren,
    input  logic [31:0]         conf_addr,
    input  logic [DATA_W-1:0]   conf_wdata,
    output logic [DATA_W-1:0]   conf_rdata,
    output logic                print_valid,
    output logic [7:0]          print_value,
    output logic                print_ovf,
    input  logic                print_ready
);

    localparam int unsigned NB     = DATA_W / 8;
    localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
    localparam int unsigned PDEPTH = 1 << PFIFO_LOG2;
    localparam logic [PFIFO_LOG2:0] PCOUNT_FULL = (PFIFO_LOG2 + 1)'(PDEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic                  cpu_req;
    logic [DEPTH_LOG2-1:0] cpu_idx;
    logic [DEPTH_LOG2-1:0] conf_idx;
    logic                  in_range;
    logic                  is_print;
    logic [DATA_W-1:0]     rsp_data;
    logic                  rsp_err;
    logic                  mem_we;
    logic                  push_req;

    logic [7:0]            pfifo [PDEPTH];
    logic [PFIFO_LOG2-1:0] wptr_q, rptr_q;
    logic [PFIFO_LOG2:0]   count_q;
    logic                  ovf_q;
    logic                  pop, push;

    logic [RD_LAT-1:0]     pv_q;
    logic [RD_LAT-1:0]     pe_q;
    logic [DATA_W-1:0]     pd_q [RD_LAT];

    logic unused_conf_bits;
    assign unused_conf_bits = ^conf_addr[31:DEPTH_LOG2];

    assign cpu_req  = mem_wren | mem_rden;
    assign cpu_idx  = mem_addr[DEPTH_LOG2-1:0];
    assign conf_idx = conf_addr[DEPTH_LOG2-1:0];
    assign in_range = (mem_addr >> DEPTH_LOG2) == 32'd0;
    assign is_print = mem_addr == PRINT_ADDR;

    // Response is formed from pre-write state, so every response is read-first.
    always_comb begin
        rsp_data = '0;
        rsp_err  = 1'b0;
        mem_we   = 1'b0;
        push_req = 1'b0;
        if (is_print) begin
            rsp_data = DATA_W'(count_q);
            push_req = mem_wren & mem_wstrb[0];
        end else if (in_range) begin
            rsp_data = mem[cpu_idx];
            if (mem_wren) begin
                // The config port owns the array while selected, which also covers
                // same-word collisions with a config write.
                if (conf_sel) rsp_err = 1'b1;
                else          mem_we  = 1'b1;
            end
        end else begin
            rsp_err = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (conf_sel && conf_wren) begin
            mem[conf_idx] <= conf_wdata;
        end
        if (mem_we) begin
            for (int b = 0; b < NB; b++) begin
                if (mem_wstrb[b]) mem[cpu_idx][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            conf_rdata <= '0;
        end else if (conf_sel && conf_rden) begin
            conf_rdata <= mem[conf_idx];
        end
    end

    // Response pipeline; the last stage drives the CPU outputs directly. Data only
    // advances with a valid token so mem_rdata holds between responses.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pv_q <= '0;
            pe_q <= '0;
            for (int i = 0; i < RD_LAT; i++) pd_q[i] <= '0;
        end else begin
            pv_q[0] <= cpu_req;
            pe_q[0] <= cpu_req & rsp_err;
            if (cpu_req) pd_q[0] <= rsp_data;
            for (int i = 1; i < RD_LAT; i++) begin
                pv_q[i] <= pv_q[i-1];
                pe_q[i] <= pe_q[i-1];
                if (pv_q[i-1]) pd_q[i] <= pd_q[i-1];
            end
        end
    end

    assign mem_ready = pv_q[RD_LAT-1];
    assign mem_err   = pe_q[RD_LAT-1];
    assign mem_rdata = pd_q[RD_LAT-1];

    // Print FIFO: a full FIFO still accepts a push when the head pops this cycle.
    assign print_valid = count_q != '0;
    assign print_value = print_valid ? pfifo[rptr_q] : 8'h00;
    assign print_ovf   = ovf_q;
    assign pop         = print_valid & print_ready;
    assign push        = push_req & ((count_q != PCOUNT_FULL) | pop);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (push) wptr_q <= wptr_q + PFIFO_LOG2'(1);
            if (pop)  rptr_q <= rptr_q + PFIFO_LOG2'(1);
            if (push && !pop)      count_q <= count_q + (PFIFO_LOG2 + 1)'(1);
            else if (pop && !push) count_q <= count_q - (PFIFO_LOG2 + 1)'(1);
            if (push_req && !push) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pfifo[wptr_q] <= mem_wdata[7:0];
`ifndef SYNTHESIS
            $write("%c", mem_wdata[7:0]);
`endif
        end
    end

endmodule

// File: tb/tb_dtcm_ctrl.sv
// Bench for dtcm_ctrl: two instances (RD_LAT=1 and RD_LAT=3) driven by the same stimulus,
// each compared every cycle against a transaction-level model of memory, responses,
// config reads and the print FIFO.
module tb_dtcm_ctrl;

    localparam logic [31:0] PRINT_ADDR = 32'h0400_0000;
    localparam int          TOP_IDX    = (1 << 14) - 1;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        mem_wren = 1'b0, mem_rden = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [3:0]  mem_wstrb = '0;
    logic [31:0] mem_wdata = '0;
    logic        conf_sel = 1'b0, conf_rden = 1'b0, conf_wren = 1'b0;
    logic [31:0] conf_addr = '0, conf_wdata = '0;
    logic        print_ready = 1'b0;

    logic [31:0] rdata_a, rdata_b, crd_a, crd_b;
    logic        ready_a, ready_b, err_a, err_b;
    logic        pv_a, pv_b, povf_a, povf_b;
    logic [7:0]  pval_a, pval_b;

    always #5 clk = ~clk;

    dtcm_ctrl u_dut_a (
        .clk(clk), .resetn(resetn),
        .mem_wren(mem_wren), .mem_rden(mem_rden), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_rdata(rdata_a), .mem_ready(ready_a), .mem_err(err_a),
        .conf_sel(conf_sel), .conf_rden(conf_rden), .conf_wren(conf_wren),
        .conf_addr(conf_addr), .conf_wdata(conf_wdata), .conf_rdata(crd_a),
        .print_valid(pv_a), .print_value(pval_a), .print_ovf(povf_a),
        .print_ready(print_ready)
    );

    dtcm_ctrl #(.RD_LAT(3)) u_dut_b (
        .clk(clk), .resetn(resetn),
        .mem_wren(mem_wren), .mem_rden(mem_rden), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_rdata(rdata_b), .mem_ready(ready_b), .mem_err(err_b),
        .conf_sel(conf_sel), .conf_rden(conf_rden), .conf_wren(conf_wren),
        .conf_addr(conf_addr), .conf_wdata(conf_wdata), .conf_rdata(crd_b),
        .print_valid(pv_b), .print_value(pval_b), .print_ovf(povf_b),
        .print_ready(print_ready)
    );

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    rsp_t        qa[$], qb[$];
    logic [31:0] mdl_mem [int];
    logic [7:0]  mdl_fifo[$];
    logic        mdl_ovf = 1'b0;
    logic [31:0] exp_conf = '0;
    logic [31:0] last_a = '0, last_b = '0;
    int          cyc = 0;
    int          n_checks = 0, n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] mdl_rd(input int idx);
        return mdl_mem.exists(idx) ? mdl_mem[idx] : 32'h0;
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_apply();
        logic [31:0] d;
        logic        e;
        rsp_t        r;
        int          occ;
        bit          pop;
        occ = mdl_fifo.size();
        pop = (occ > 0) && print_ready;
        d = '0;
        e = 1'b0;
        if (mem_addr == PRINT_ADDR) begin
            d = 32'(occ);
        end else if (mem_addr < 32'h4000) begin
            d = mdl_rd(int'(mem_addr));
            e = mem_wren && conf_sel;
        end else begin
            e = 1'b1;
        end
        if (mem_wren || mem_rden) begin
            r.data = d;
            r.err  = e;
            r.due  = cyc;
            qa.push_back(r);
            r.due  = cyc + 2;
            qb.push_back(r);
        end
        if (conf_sel && conf_rden) exp_conf = mdl_rd(int'(conf_addr[13:0]));
        if (conf_sel && conf_wren) mdl_mem[int'(conf_addr[13:0])] = conf_wdata;
        if (mem_wren && !conf_sel && mem_addr < 32'h4000 && mem_addr != PRINT_ADDR) begin
            logic [31:0] w;
            w = mdl_rd(int'(mem_addr));
            for (int b = 0; b < 4; b++) if (mem_wstrb[b]) w[b*8 +: 8] = mem_wdata[b*8 +: 8];
            mdl_mem[int'(mem_addr)] = w;
        end
        if (pop) void'(mdl_fifo.pop_front());
        if (mem_wren && mem_addr == PRINT_ADDR && mem_wstrb[0]) begin
            if (occ < 8 || pop) mdl_fifo.push_back(mem_wdata[7:0]);
            else mdl_ovf = 1'b1;
        end
    endtask

    task automatic check_all();
        logic [7:0] head;
        if (qa.size() > 0 && qa[0].due == cyc) begin
            check("a_ready", ready_a, 1);
            check("a_err", err_a, qa[0].err);
            check("a_rdata", rdata_a, qa[0].data);
            last_a = qa[0].data;
            void'(qa.pop_front());
        end else begin
            check("a_ready_idle", ready_a, 0);
            check("a_err_idle", err_a, 0);
            check("a_rdata_hold", rdata_a, last_a);
        end
        if (qb.size() > 0 && qb[0].due == cyc) begin
            check("b_ready", ready_b, 1);
            check("b_err", err_b, qb[0].err);
            check("b_rdata", rdata_b, qb[0].data);
            last_b = qb[0].data;
            void'(qb.pop_front());
        end else begin
            check("b_ready_idle", ready_b, 0);
            check("b_err_idle", err_b, 0);
            check("b_rdata_hold", rdata_b, last_b);
        end
        head = (mdl_fifo.size() > 0) ? mdl_fifo[0] : 8'h00;
        check("a_print_valid", pv_a, mdl_fifo.size() > 0);
        check("a_print_value", pval_a, head);
        check("a_print_ovf", povf_a, mdl_ovf);
        check("b_print_valid", pv_b, mdl_fifo.size() > 0);
        check("b_print_value", pval_b, head);
        check("b_print_ovf", povf_b, mdl_ovf);
        check("a_conf_rdata", crd_a, exp_conf);
        check("b_conf_rdata", crd_b, exp_conf);
    endtask

    task automatic cycle();
        model_apply();
        @(posedge clk);
        @(negedge clk);
        check_all();
        cyc++;
    endtask

    task automatic idle();
        mem_wren = 0; mem_rden = 0; mem_addr = '0; mem_wstrb = '0; mem_wdata = '0;
        conf_sel = 0; conf_rden = 0; conf_wren = 0; conf_addr = '0; conf_wdata = '0;
    endtask

    task automatic cpu(input logic wr, input logic [31:0] addr, input logic [3:0] strb,
                       input logic [31:0] data);
        idle();
        mem_wren = wr; mem_rden = !wr; mem_addr = addr; mem_wstrb = strb; mem_wdata = data;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, {ready_a, ready_b}, 2'b00);
        check({tag, "_err"}, {err_a, err_b}, 2'b00);
        check({tag, "_rdata"}, {rdata_a, rdata_b}, 64'h0);
        check({tag, "_conf_rdata"}, {crd_a, crd_b}, 64'h0);
        check({tag, "_print"}, {pv_a, pval_a, povf_a, pv_b, pval_b, povf_b}, 20'h0);
    endtask

    function automatic int pick_idx();
        int r;
        r = $urandom_range(0, 32);
        return (r == 32) ? TOP_IDX : r;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        #1 resetn = 1'b0;
        #2 check_reset_outputs("por");
        @(negedge clk);
        resetn = 1'b1;

        // Load a known image through the config port.
        for (int i = 0; i <= 32; i++) begin
            idle();
            conf_sel = 1; conf_wren = 1;
            conf_addr = (i == 32) ? TOP_IDX : i;
            conf_wdata = $urandom;
            cycle();
        end

        // Byte-strobe merge over a config-written word.
        idle(); conf_sel = 1; conf_wren = 1; conf_addr = 5; conf_wdata = 32'h1122_3344;
        cycle();
        cpu(1, 5, 4'b0010, 32'h0000_AA00);
        cycle();
        check("d1_wr_ready", ready_a, 1);
        cpu(0, 5, 4'b0000, 32'h0);
        cycle();
        check("d1_rd_ready", ready_a, 1);
        check("d1_rdata", rdata_a, 32'h1122_AA44);

        // Back-to-back reads; the RD_LAT=3 instance must pulse three cycles in a row.
        for (int i = 0; i < 3; i++) begin
            cpu(0, i, 4'b0, 32'h0);
            cycle();
        end
        idle();
        cycle();
        check("d2_b_ready_2", ready_b, 1);
        cycle();
        check("d2_b_ready_3", ready_b, 1);
        cycle();
        check("d2_b_after", ready_b, 0);

        // Fill the print FIFO, overflow with a ninth byte, then drain.
        print_ready = 0;
        for (int i = 0; i < 9; i++) begin
            cpu(1, PRINT_ADDR, 4'b0001, 32'h30 + 32'(i + 1));
            cycle();
        end
        cpu(0, PRINT_ADDR, 4'b0, 32'h0);
        cycle();
        check("d3_occupancy", rdata_a, 32'd8);
        check("d3_ovf", povf_a, 1);
        idle();
        print_ready = 1;
        for (int i = 0; i < 8; i++) begin
            check("d3_drain", pval_a, 8'h31 + 8'(i));
            cycle();
        end
        check("d3_empty", pv_a, 0);
        print_ready = 0;

        // Out-of-range read.
        cpu(0, 32'h0001_0000, 4'b0, 32'h0);
        cycle();
        check("d4_err", err_a, 1);
        check("d4_rdata", rdata_a, 32'h0);

        // Same-cycle config and CPU write to word 7.
        cpu(1, 7, 4'hF, 32'h1234_5678);
        conf_sel = 1; conf_wren = 1; conf_addr = 7; conf_wdata = 32'hCAFE_F00D;
        cycle();
        check("d5_err", err_a, 1);
        cpu(0, 7, 4'b0, 32'h0);
        cycle();
        check("d5_rdata", rdata_a, 32'hCAFE_F00D);

        // Reset with two reads in flight in the RD_LAT=3 instance and a non-empty FIFO.
        cpu(1, PRINT_ADDR, 4'b0001, 32'h61);
        cycle();
        cpu(0, 1, 4'b0, 32'h0);
        cycle();
        cpu(0, 2, 4'b0, 32'h0);
        cycle();
        idle();
        resetn = 1'b0;
        #2 check_reset_outputs("mid");
        qa.delete(); qb.delete(); mdl_fifo.delete();
        mdl_ovf = 0; exp_conf = '0; last_a = '0; last_b = '0;
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        // Contents survive reset.
        cpu(0, 7, 4'b0, 32'h0);
        cycle();
        check("d6_retained", rdata_a, 32'hCAFE_F00D);

        // Randomized traffic.
        for (int n = 0; n < 500; n++) begin
            int k;
            idle();
            k = $urandom_range(0, 9);
            mem_wren  = $urandom_range(0, 2) == 0;
            mem_rden  = $urandom_range(0, 1) == 1;
            mem_wstrb = 4'($urandom);
            mem_wdata = $urandom;
            case (k)
                6: begin
                    mem_addr = PRINT_ADDR;
                    mem_wdata[7:0] = 8'($urandom_range(8'h61, 8'h7a));
                end
                7: mem_addr = 32'h0000_4000;
                8: mem_addr = $urandom | 32'h8000_0000;
                9: mem_addr = 32'h0001_0000;
                default: mem_addr = pick_idx();
            endcase
            conf_sel   = $urandom_range(0, 5) == 0;
            conf_rden  = $urandom_range(0, 1) == 1;
            conf_wren  = $urandom_range(0, 2) == 0;
            conf_addr  = pick_idx();
            conf_wdata = $urandom;
            print_ready = $urandom_range(0, 2) != 0;
            cycle();
        end
        idle();
        for (int i = 0; i < 4; i++) cycle();

        $write("\n");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dtcm_ctrl.md
DTCM_CTRL -- requirements
Module: dtcm_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, word width in bits (multiple of 8, 8..64).
REQ-002 SHALL have parameter DEPTH_LOG2, default 14, log2 of word count.
REQ-003 SHALL have parameter RD_LAT, default 1, request-to-response latency in cycles (1..3).
REQ-004 SHALL have parameter PRINT_ADDR, default 32'h0400_0000, print MMIO address.
REQ-005 SHALL have parameter PFIFO_LOG2, default 3, log2 of print FIFO depth.
REQ-006 SHALL have clk input, 1 bit, clock; all logic on rising edge.
REQ-007 SHALL have resetn input, 1 bit, asynchronous active-low reset.
REQ-008 SHALL have CPU port inputs: mem_wren (1), mem_rden (1), mem_addr (32, word index), mem_wstrb (DATA_W/8), mem_wdata (DATA_W).
REQ-009 SHALL have CPU port outputs: mem_rdata (DATA_W), mem_ready (1), mem_err (1).
REQ-010 SHALL have config port inputs: conf_sel (1), conf_rden (1), conf_wren (1), conf_addr (32), conf_wdata (DATA_W).
REQ-011 SHALL have conf_rdata output, DATA_W bits.
REQ-012 SHALL have print outputs print_valid (1), print_value (8), print_ovf (1), and print input print_ready (1).

Function
REQ-013 SHALL store 2^DEPTH_LOG2 words as one inferred behavioural array with per-byte write enables; no vendor macros.
REQ-014 SHALL accept one CPU request per cycle when mem_wren|mem_rden; mem_wren has priority when both are high and counts as one request.
REQ-015 SHALL assert mem_ready for exactly one cycle, RD_LAT cycles after each accepted request; requests are fully pipelined and responses stay in order.
REQ-016 SHALL present mem_rdata together with mem_ready and hold it until the next response.
REQ-017 SHALL decode the CPU address as follows; in-range means mem_addr[31:DEPTH_LOG2]==0.
  - In-range: write bytes enabled by mem_wstrb into word mem_addr[DEPTH_LOG2-1:0].
  - Reads and write responses return pre-write data (read-first).
REQ-018 SHALL treat a write to PRINT_ADDR with mem_wstrb[0]=1 as a print push of mem_wdata[7:0]; memory is not modified.
  - A read of PRINT_ADDR returns the FIFO occupancy, zero-extended.
REQ-019 SHALL handle any other address as follows:
  - no memory write;
  - mem_rdata=0;
  - mem_err=1 in the same cycle as mem_ready.
REQ-020 SHALL, while conf_sel=1, suppress CPU memory writes and signal mem_err with mem_ready; CPU reads still complete.
REQ-021 SHALL serve the config port (conf_sel=1) as follows:
  - writes all bytes of conf_addr[DEPTH_LOG2-1:0] on conf_wren;
  - conf_rdata is registered, valid 1 cycle after conf_rden, read-first.
REQ-022 SHALL, on a same-cycle same-word write from both ports, apply the config write in full; the CPU write is dropped and flagged via mem_err.
REQ-023 SHALL implement the print FIFO with 2^PFIFO_LOG2 entries and first-word-fall-through output.
  - print_valid = non-empty; print_value = head entry.
  - An entry pops on print_valid&print_ready.
REQ-024 SHALL accept a push when the FIFO is not full or a pop occurs in the same cycle.
  - Otherwise the byte is dropped and print_ovf is set.
  - print_ovf is sticky until reset.
REQ-025 SHALL, on a simultaneous push and pop, keep occupancy unchanged; pointers wrap modulo depth.
REQ-026 SHALL, in simulation only, $write each accepted print byte as %c.

Reset
REQ-027 SHALL, on resetn=0, asynchronously clear:
  - mem_ready, mem_err, mem_rdata;
  - conf_rdata;
  - print_valid, print_value, print_ovf;
  - FIFO pointers and occupancy.
REQ-028 SHALL discard all in-flight responses when reset is asserted mid-operation; no mem_ready follows reset release.
REQ-029 SHALL NOT reset array contents.

Verification
REQ-030 SHALL be verified by these directed scenarios (defaults unless stated):
  - Config write word 5 = 0x11223344, then CPU write addr 5, wstrb 4'b0010, data 0x0000AA00, then CPU read addr 5 -> rdata 0x1122AA44, mem_ready 1 cycle after each request.
  - RD_LAT=3, back-to-back reads of addr 0,1,2 -> three consecutive mem_ready pulses at cycles +3,+4,+5 with data in order.
  - Eight writes to PRINT_ADDR with print_ready=0, then a ninth -> occupancy 8, print_ovf=1; raise print_ready -> bytes 1..8 drained in order, one per cycle.
  - CPU read of addr 0x0001_0000 -> mem_rdata=0, mem_err=1 with mem_ready; memory unchanged.
  - Same-cycle conf_wren and CPU write to word 7 -> word 7 holds the conf data, mem_err=1.
  - resetn pulse low while 2 reads are in flight -> no mem_ready after release, FIFO empty, print_ovf=0.
